// File: rtl/controller_sequencer_pkg.sv
// Shared constants for the SAP-1 control unit: widths, opcodes, control-word bits and words.
package controller_sequencer_pkg;

  localparam int unsigned SAP_NUM_T = 6;
  localparam int unsigned SAP_OP_W  = 4;
  localparam int unsigned CW_W      = 12;

  localparam logic [SAP_OP_W-1:0] OP_LDA = 4'b0000;
  localparam logic [SAP_OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [SAP_OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [SAP_OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [SAP_OP_W-1:0] OP_HLT = 4'b1111;

  // Bit positions inside the control word
  localparam int unsigned CP_B     = 11;
  localparam int unsigned EP_B     = 10;
  localparam int unsigned LM_BAR_B = 9;
  localparam int unsigned CE_BAR_B = 8;
  localparam int unsigned LI_BAR_B = 7;
  localparam int unsigned EI_BAR_B = 6;
  localparam int unsigned LA_BAR_B = 5;
  localparam int unsigned EA_B     = 4;
  localparam int unsigned SU_B     = 3;
  localparam int unsigned EU_B     = 2;
  localparam int unsigned LB_BAR_B = 1;
  localparam int unsigned LO_BAR_B = 0;

  // Named control words (active-low loads/enables idle high)
  localparam logic [CW_W-1:0] CW_IDLE = 12'h3E3;
  localparam logic [CW_W-1:0] CW_T1   = 12'h5E3;
  localparam logic [CW_W-1:0] CW_T2   = 12'hBE3;
  localparam logic [CW_W-1:0] CW_T3   = 12'h263;
  localparam logic [CW_W-1:0] CW_LDA4 = 12'h1A3;
  localparam logic [CW_W-1:0] CW_LDA5 = 12'h2C3;
  localparam logic [CW_W-1:0] CW_ADD4 = 12'h1A3;
  localparam logic [CW_W-1:0] CW_ADD5 = 12'h2E1;
  localparam logic [CW_W-1:0] CW_ADD6 = 12'h3C7;
  localparam logic [CW_W-1:0] CW_SUB4 = 12'h1A3;
  localparam logic [CW_W-1:0] CW_SUB5 = 12'h2E1;
  localparam logic [CW_W-1:0] CW_SUB6 = 12'h3CF;
  localparam logic [CW_W-1:0] CW_OUT4 = 12'h3F2;

  // One-hot T-states
  typedef enum logic [SAP_NUM_T-1:0] {
    ST_T1 = 6'b000001,
    ST_T2 = 6'b000010,
    ST_T3 = 6'b000100,
    ST_T4 = 6'b001000,
    ST_T5 = 6'b010000,
    ST_T6 = 6'b100000
  } t_state_e;

endpackage

// File: rtl/controller_sequencer_if.sv
// Opcode in, control word / ring state / halt flag out.
interface controller_sequencer_if;
  import controller_sequencer_pkg::*;

  logic [SAP_OP_W-1:0]  opcode;
  logic [CW_W-1:0]      cont_signal;
  logic [SAP_NUM_T-1:0] t_state;
  logic                 hlt;

  modport master (output opcode, input cont_signal, input t_state, input hlt);
  modport slave  (input opcode, output cont_signal, output t_state, output hlt);
endinterface

// File: rtl/controller_sequencer_ring_counter.sv
// One-hot T-state ring with hold and self-recovery from illegal states.
module controller_sequencer_ring_counter #(
  parameter int unsigned NUM_T = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             hold,
  output logic [NUM_T-1:0] t
);

  localparam logic [NUM_T-1:0] T_FIRST = NUM_T'(1);

  logic [NUM_T-1:0] t_q;
  logic [NUM_T-1:0] t_d;

  // State register, synchronous clear to T1
  always_ff @(posedge clk) begin
    if (clr) t_q <= T_FIRST;
    else     t_q <= t_d;
  end

  // Next state: hold, recover, or rotate left by one
  always_comb begin
    t_d = t_q;
    if (hold)               t_d = t_q;
    else if (!$onehot(t_q)) t_d = T_FIRST;
    else                    t_d = {t_q[NUM_T-2:0], t_q[NUM_T-1]};
  end

  assign t = t_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: ring counter, sticky halt flag and control-word decoder.
module controller_sequencer
  import controller_sequencer_pkg::*;
#(
  parameter int unsigned NUM_T = SAP_NUM_T,
  parameter int unsigned OP_W  = SAP_OP_W
) (
  input  logic                   clk,
  input  logic                   clr,
  controller_sequencer_if.slave  bus
);

  logic [NUM_T-1:0] t;
  logic [OP_W-1:0]  op;
  logic             halted_q;
  logic             halted_d;
  logic             hlt_now;
  logic             hold;
  logic [CW_W-1:0]  cw;

  assign op      = bus.opcode;
  assign hlt_now = (t == ST_T4) && (op == OP_HLT);
  assign hold    = halted_q | hlt_now;

  controller_sequencer_ring_counter #(.NUM_T(NUM_T)) u_ring (
    .clk  (clk),
    .clr  (clr),
    .hold (hold),
    .t    (t)
  );

  // Halt flag register, cleared only by clr
  always_ff @(posedge clk) begin
    if (clr) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end

  // Halt flag next state: set on HLT in T4, then sticky
  always_comb begin
    halted_d = halted_q;
    if (hlt_now) halted_d = 1'b1;
  end

  // Control-word decode of current T-state and opcode; idle under clear or halt
  always_comb begin
    cw = CW_IDLE;
    if (!clr && !halted_q) begin
      case (t)
        ST_T1: cw = CW_T1;
        ST_T2: cw = CW_T2;
        ST_T3: cw = CW_T3;
        ST_T4: begin
          case (op)
            OP_LDA:  cw = CW_LDA4;
            OP_ADD:  cw = CW_ADD4;
            OP_SUB:  cw = CW_SUB4;
            OP_OUT:  cw = CW_OUT4;
            default: cw = CW_IDLE;
          endcase
        end
        ST_T5: begin
          case (op)
            OP_LDA:  cw = CW_LDA5;
            OP_ADD:  cw = CW_ADD5;
            OP_SUB:  cw = CW_SUB5;
            default: cw = CW_IDLE;
          endcase
        end
        ST_T6: begin
          case (op)
            OP_ADD:  cw = CW_ADD6;
            OP_SUB:  cw = CW_SUB6;
            default: cw = CW_IDLE;
          endcase
        end
        default: cw = CW_IDLE;
      endcase
    end
  end

  assign bus.cont_signal = cw;
  assign bus.t_state     = t;
  assign bus.hlt         = halted_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Randomized bench for the SAP-1 control unit against a step-number reference model.
module tb_controller_sequencer;
  import controller_sequencer_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  controller_sequencer_if bus ();
  controller_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: step number 1..6 and a halt bit
  int m_t    = 1;
  bit m_halt = 1'b0;

  function automatic logic [11:0] exp_cw(int t, logic [3:0] op, bit halt, logic c);
    logic [11:0] ex [3];
    if (c || halt) return 12'h3E3;
    if (t == 1) return 12'h5E3;
    if (t == 2) return 12'hBE3;
    if (t == 3) return 12'h263;
    case (op)
      4'h0:    ex = '{12'h1A3, 12'h2C3, 12'h3E3};
      4'h1:    ex = '{12'h1A3, 12'h2E1, 12'h3C7};
      4'h2:    ex = '{12'h1A3, 12'h2E1, 12'h3CF};
      4'hE:    ex = '{12'h3F2, 12'h3E3, 12'h3E3};
      default: ex = '{12'h3E3, 12'h3E3, 12'h3E3};
    endcase
    if (t >= 4 && t <= 6) return ex[t-4];
    return 12'h3E3;
  endfunction

  function automatic logic [5:0] exp_t(int t);
    logic [5:0] one;
    one = 6'd1;
    return 6'(one << (t - 1));
  endfunction

  // Apply one clock edge to the model and the DUT; return at the following negedge
  task automatic advance();
    if (clr) begin
      m_t = 1;
      m_halt = 1'b0;
    end else if (m_halt) begin
      m_t = m_t;
    end else if (m_t == 4 && bus.opcode == 4'hF) begin
      m_halt = 1'b1;
    end else begin
      m_t = (m_t == 6) ? 1 : m_t + 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.opcode = 4'($urandom);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      advance();
      bus.opcode = 4'($urandom);
      #1;
      n_tests++;
      if (bus.cont_signal !== 12'h3E3) begin
        n_fail++; $display("FAIL reset_cw got %h exp 3e3", bus.cont_signal);
      end
      n_tests++;
      if (bus.t_state !== 6'b000001) begin
        n_fail++; $display("FAIL reset_t got %b exp 000001", bus.t_state);
      end
      n_tests++;
      if (bus.hlt !== 1'b0) begin
        n_fail++; $display("FAIL reset_hlt got %b exp 0", bus.hlt);
      end
    end
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.opcode = 4'($urandom);
      #1;
      n_tests++;
      if (bus.cont_signal !== exp_cw(m_t, bus.opcode, m_halt, clr)) begin
        n_fail++; $display("FAIL fetch_cw T%0d got %h exp %h", m_t, bus.cont_signal, exp_cw(m_t, bus.opcode, m_halt, clr));
      end
      n_tests++;
      if (bus.t_state !== exp_t(m_t)) begin
        n_fail++; $display("FAIL fetch_t got %b exp %b", bus.t_state, exp_t(m_t));
      end
      advance();
    end
  endtask

  // Runs T4..T6 with the given opcode then the next fetch; starts and ends in T4
  task automatic test_instr(input logic [3:0] op);
    for (int i = 0; i < 6; i++) begin
      bus.opcode = (m_t >= 4) ? op : 4'($urandom_range(0, 14));
      #1;
      n_tests++;
      if (bus.cont_signal !== exp_cw(m_t, bus.opcode, m_halt, clr)) begin
        n_fail++; $display("FAIL instr_%h_cw T%0d got %h exp %h", op, m_t, bus.cont_signal, exp_cw(m_t, bus.opcode, m_halt, clr));
      end
      n_tests++;
      if (bus.t_state !== exp_t(m_t) || bus.hlt !== 1'b0) begin
        n_fail++; $display("FAIL instr_%h_state got %b/%b exp %b/0", op, bus.t_state, bus.hlt, exp_t(m_t));
      end
      advance();
    end
  endtask

  // CLR during T5 of ADD aborts before the T6 word appears
  task automatic test_clr_abort();
    bus.opcode = OP_ADD;
    advance();
    #1;
    n_tests++;
    if (bus.cont_signal !== 12'h2E1 || bus.t_state !== 6'b010000) begin
      n_fail++; $display("FAIL abort_t5 got %h/%b exp 2e1/010000", bus.cont_signal, bus.t_state);
    end
    clr = 1'b1;
    #1;
    n_tests++;
    if (bus.cont_signal !== 12'h3E3) begin
      n_fail++; $display("FAIL abort_clr_cw got %h exp 3e3", bus.cont_signal);
    end
    advance();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.opcode = 4'($urandom);
      #1;
      n_tests++;
      if (bus.cont_signal !== exp_cw(m_t, bus.opcode, m_halt, clr) || bus.t_state !== exp_t(m_t)) begin
        n_fail++; $display("FAIL abort_refetch T%0d got %h/%b exp %h/%b", m_t, bus.cont_signal, bus.t_state, exp_cw(m_t, bus.opcode, m_halt, clr), exp_t(m_t));
      end
      advance();
    end
  endtask

  // HLT in T4 freezes the ring; only CLR releases it
  task automatic test_halt();
    bus.opcode = OP_HLT;
    #1;
    n_tests++;
    if (bus.cont_signal !== 12'h3E3 || bus.hlt !== 1'b0) begin
      n_fail++; $display("FAIL halt_t4 got %h/%b exp 3e3/0", bus.cont_signal, bus.hlt);
    end
    advance();
    for (int i = 0; i < 20; i++) begin
      bus.opcode = 4'($urandom);
      #1;
      n_tests++;
      if (bus.t_state !== 6'b001000 || bus.cont_signal !== 12'h3E3 || bus.hlt !== 1'b1) begin
        n_fail++; $display("FAIL halt_hold cyc %0d got %b/%h/%b exp 001000/3e3/1", i, bus.t_state, bus.cont_signal, bus.hlt);
      end
      n_tests++;
      if (bus.cont_signal[CP_B] !== 1'b0) begin
        n_fail++; $display("FAIL halt_cp got %b exp 0", bus.cont_signal[CP_B]);
      end
      advance();
    end
    clr = 1'b1;
    advance();
    clr = 1'b0;
    #1;
    n_tests++;
    if (bus.t_state !== 6'b000001 || bus.hlt !== 1'b0 || bus.cont_signal !== 12'h5E3) begin
      n_fail++; $display("FAIL halt_release got %b/%b/%h exp 000001/0/5e3", bus.t_state, bus.hlt, bus.cont_signal);
    end
    for (int i = 0; i < 3; i++) advance();
  endtask

  // Free-running random opcodes with occasional clears
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 39) == 0);
      bus.opcode = 4'($urandom);
      #1;
      n_tests++;
      if (bus.cont_signal !== exp_cw(m_t, bus.opcode, m_halt, clr)) begin
        n_fail++; $display("FAIL rand_cw cyc %0d got %h exp %h", i, bus.cont_signal, exp_cw(m_t, bus.opcode, m_halt, clr));
      end
      n_tests++;
      if (bus.t_state !== exp_t(m_t) || bus.hlt !== m_halt) begin
        n_fail++; $display("FAIL rand_state cyc %0d got %b/%b exp %b/%b", i, bus.t_state, bus.hlt, exp_t(m_t), m_halt);
      end
      advance();
    end
    clr = 1'b1;
    advance();
    clr = 1'b0;
  endtask

  // Non-one-hot ring value recovers to T1 on the next edge
  task automatic test_illegal();
    bus.opcode = 4'h5;
    force dut.u_ring.t_q = 6'b000011;
    #1;
    release dut.u_ring.t_q;
    #1;
    n_tests++;
    if (bus.t_state !== 6'b000011 || bus.cont_signal !== 12'h3E3) begin
      n_fail++; $display("FAIL illegal_decode got %b/%h exp 000011/3e3", bus.t_state, bus.cont_signal);
    end
    @(posedge clk);
    @(negedge clk);
    m_t = 1;
    #1;
    n_tests++;
    if (bus.t_state !== exp_t(m_t) || bus.cont_signal !== 12'h5E3) begin
      n_fail++; $display("FAIL illegal_recover got %b/%h exp 000001/5e3", bus.t_state, bus.cont_signal);
    end
  endtask

  initial begin
    bus.opcode = 4'h0;
    test_reset();
    test_instr(OP_LDA);
    test_instr(OP_ADD);
    test_instr(OP_SUB);
    test_instr(OP_OUT);
    test_instr(4'b0101);
    test_clr_abort();
    test_halt();
    test_random();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
